// File: rtl/btn_debounce_events_pkg.sv
// Shared constants for the button debounce/event block: button width and
// default timing parameters, plus a counter-width helper.
package btn_debounce_events_pkg;

    localparam int unsigned BTN_W              = 7;
    localparam int unsigned TICK_DIV_DEF       = 25000;
    localparam int unsigned DEBOUNCE_TICKS_DEF = 10;
    localparam int unsigned LONG_TICKS_DEF     = 1000;
    localparam int unsigned COMBO_TICKS_DEF    = 2000;
    localparam logic [BTN_W-1:0] ACTIVE_LOW_DEF = 7'b0000001;

    // Bits needed to hold values 0..max_val inclusive.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/btn_debounce_bit.sv
// One button channel: 2-flop synchronizer, polarity normalization, tick-based
// debounce, hold counter and registered press/release/long event pulses.
module btn_debounce_bit
    import btn_debounce_events_pkg::*;
#(
    parameter int unsigned C_debounce_ticks = DEBOUNCE_TICKS_DEF,
    parameter int unsigned C_long_ticks     = LONG_TICKS_DEF,
    parameter logic        C_active_low     = 1'b0
) (
    input  logic clk_25mhz,
    input  logic reset,
    input  logic tick,
    input  logic btn_raw,
    output logic btn_stable,
    output logic btn_press,
    output logic btn_release,
    output logic btn_long
);

    localparam int unsigned DebW  = cnt_width(C_debounce_ticks);
    localparam int unsigned HoldW = cnt_width(C_long_ticks);

    logic             sync1_q, sync2_q, sample_q;
    logic [DebW-1:0]  deb_cnt_q, deb_cnt_d;
    logic [HoldW-1:0] hold_q, hold_d;
    logic             stable_q, stable_d;
    logic             press_q, release_q, long_q;
    logic             long_d;

    // Synchronizer and normalized sample register; reset to "not pressed".
    always_ff @(posedge clk_25mhz) begin
        if (reset) begin
            sync1_q  <= C_active_low;
            sync2_q  <= C_active_low;
            sample_q <= 1'b0;
        end else begin
            sync1_q  <= btn_raw;
            sync2_q  <= sync1_q;
            sample_q <= sync2_q ^ C_active_low;
        end
    end

    // Debounce, hold and event next-state logic.
    always_comb begin
        deb_cnt_d = deb_cnt_q;
        stable_d  = stable_q;
        hold_d    = hold_q;
        long_d    = 1'b0;

        // Any cycle of agreement restarts the count, so sub-tick glitches never accumulate.
        if (sample_q == stable_q) begin
            deb_cnt_d = '0;
        end else if (tick) begin
            if (deb_cnt_q == DebW'(C_debounce_ticks - 1)) begin
                stable_d  = ~stable_q;
                deb_cnt_d = '0;
            end else begin
                deb_cnt_d = deb_cnt_q + 1'b1;
            end
        end

        if (!stable_q) begin
            hold_d = '0;
        end else if (tick && (hold_q != HoldW'(C_long_ticks))) begin
            hold_d = hold_q + 1'b1;
            long_d = (hold_q == HoldW'(C_long_ticks - 1));
        end
    end

    // State and event registers.
    always_ff @(posedge clk_25mhz) begin
        if (reset) begin
            deb_cnt_q <= '0;
            hold_q    <= '0;
            stable_q  <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
        end else begin
            deb_cnt_q <= deb_cnt_d;
            hold_q    <= hold_d;
            stable_q  <= stable_d;
            press_q   <= stable_d & ~stable_q;
            release_q <= ~stable_d & stable_q;
            long_q    <= long_d;
        end
    end

    assign btn_stable  = stable_q;
    assign btn_press   = press_q;
    assign btn_release = release_q;
    assign btn_long    = long_q;

endmodule

// File: rtl/btn_debounce_events.sv
// Seven-button debouncer with press/release/long-press events and a
// two-button hold combo that requests multiboot via user_programn.
module btn_debounce_events
    import btn_debounce_events_pkg::*;
#(
    parameter int unsigned       C_tick_div       = TICK_DIV_DEF,
    parameter int unsigned       C_debounce_ticks = DEBOUNCE_TICKS_DEF,
    parameter int unsigned       C_long_ticks     = LONG_TICKS_DEF,
    parameter int unsigned       C_combo_ticks    = COMBO_TICKS_DEF,
    parameter logic [BTN_W-1:0]  C_active_low     = ACTIVE_LOW_DEF
) (
    input  logic             clk_25mhz,
    input  logic             reset,
    input  logic [BTN_W-1:0] btn_raw,
    output logic [BTN_W-1:0] btn_stable,
    output logic [BTN_W-1:0] btn_press,
    output logic [BTN_W-1:0] btn_release,
    output logic [BTN_W-1:0] btn_long,
    output logic             user_programn
);

    localparam int unsigned DivW   = cnt_width(C_tick_div);
    localparam int unsigned ComboW = cnt_width(C_combo_ticks);

    logic [DivW-1:0]   div_q;
    logic              tick;
    logic [ComboW-1:0] combo_q, combo_d;
    logic              programn_q;
    logic              both_held;

    assign tick = (div_q == DivW'(C_tick_div - 1));

    // Free-running timebase divider.
    always_ff @(posedge clk_25mhz) begin
        if (reset) begin
            div_q <= '0;
        end else if (tick) begin
            div_q <= '0;
        end else begin
            div_q <= div_q + 1'b1;
        end
    end

    for (genvar i = 0; i < BTN_W; i++) begin : g_bit
        btn_debounce_bit #(
            .C_debounce_ticks(C_debounce_ticks),
            .C_long_ticks    (C_long_ticks),
            .C_active_low    (C_active_low[i])
        ) u_bit (
            .clk_25mhz  (clk_25mhz),
            .reset      (reset),
            .tick       (tick),
            .btn_raw    (btn_raw[i]),
            .btn_stable (btn_stable[i]),
            .btn_press  (btn_press[i]),
            .btn_release(btn_release[i]),
            .btn_long   (btn_long[i])
        );
    end

    assign both_held = btn_stable[0] & btn_stable[1];

    // Combo hold counter, saturating at the combo threshold.
    always_comb begin
        combo_d = combo_q;
        if (!both_held) begin
            combo_d = '0;
        end else if (tick && (combo_q != ComboW'(C_combo_ticks))) begin
            combo_d = combo_q + 1'b1;
        end
    end

    // programn is registered from the next combo value so it tracks combo_q exactly.
    always_ff @(posedge clk_25mhz) begin
        if (reset) begin
            combo_q    <= '0;
            programn_q <= 1'b1;
        end else begin
            combo_q    <= combo_d;
            programn_q <= (combo_d != ComboW'(C_combo_ticks));
        end
    end

    assign user_programn = programn_q;

endmodule

// File: tb/tb_btn_debounce_events.sv
// Randomized and directed bench for btn_debounce_events with a tick-arithmetic
// reference model.
module tb_btn_debounce_events;

    localparam int DIV   = 4;
    localparam int DEB   = 3;
    localparam int LONG  = 20;
    localparam int COMBO = 10;
    localparam logic [6:0] POL = 7'b0000001;

    logic       clk_25mhz = 1'b0;
    logic       reset;
    logic [6:0] btn_raw;
    logic [6:0] btn_stable, btn_press, btn_release, btn_long;
    logic       user_programn;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc_n    = 0;

    always #5 clk_25mhz = ~clk_25mhz;

    btn_debounce_events #(
        .C_tick_div      (DIV),
        .C_debounce_ticks(DEB),
        .C_long_ticks    (LONG),
        .C_combo_ticks   (COMBO),
        .C_active_low    (POL)
    ) dut (
        .clk_25mhz    (clk_25mhz),
        .reset        (reset),
        .btn_raw      (btn_raw),
        .btn_stable   (btn_stable),
        .btn_press    (btn_press),
        .btn_release  (btn_release),
        .btn_long     (btn_long),
        .user_programn(user_programn)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc_n, got, exp);
        end
    endtask

    // Reference model: edges are indexed from the first edge after reset; a tick
    // happens at edge e when e mod DIV == DIV-1, so tick counts are plain division.
    int         e;
    logic [6:0] h1, h2, h3;
    logic [6:0] m_stable, m_press, m_release, m_long;
    logic       m_prog;
    int         agree [7];
    int         rise  [7];
    int         both_edge;

    function automatic int ticks_in(input int a, input int b);
        return (b + 1) / DIV - (a + 1) / DIV;
    endfunction

    task automatic model_step();
        logic [6:0] ns;
        logic       tk, both_old, both_new;
        if (reset) begin
            e = 0;
            h1 = '0; h2 = '0; h3 = '0;
            m_stable = '0; m_press = '0; m_release = '0; m_long = '0;
            m_prog = 1'b1;
            for (int i = 0; i < 7; i++) begin
                agree[i] = -1;
                rise[i]  = -1;
            end
            both_edge = -1;
        end else begin
            tk = ((e % DIV) == DIV - 1);
            ns = m_stable;
            for (int i = 0; i < 7; i++) begin
                if (h3[i] == m_stable[i]) begin
                    agree[i] = e;
                end else if (tk && ticks_in(agree[i], e) == DEB) begin
                    ns[i] = ~m_stable[i];
                    agree[i] = e;
                end
                m_long[i] = m_stable[i] && tk && (ticks_in(rise[i], e) == LONG);
                if (ns[i] && !m_stable[i]) rise[i] = e;
            end
            both_old = m_stable[0] & m_stable[1];
            m_prog = !(both_old && ticks_in(both_edge, e) >= COMBO);
            both_new = ns[0] & ns[1];
            if (both_new && !both_old) both_edge = e;
            m_press   = ns & ~m_stable;
            m_release = ~ns & m_stable;
            m_stable  = ns;
            h3 = h2;
            h2 = h1;
            h1 = btn_raw ^ POL;
            e++;
        end
    endtask

    int press_cnt [7];
    int rel_cnt   [7];
    int long_cnt  [7];
    int first_press3;

    task automatic clear_counts();
        for (int i = 0; i < 7; i++) begin
            press_cnt[i] = 0;
            rel_cnt[i]   = 0;
            long_cnt[i]  = 0;
        end
        first_press3 = -1;
    endtask

    task automatic cyc();
        model_step();
        @(posedge clk_25mhz);
        @(negedge clk_25mhz);
        cyc_n++;
        check("btn_stable", 32'(btn_stable), 32'(m_stable));
        check("btn_press", 32'(btn_press), 32'(m_press));
        check("btn_release", 32'(btn_release), 32'(m_release));
        check("btn_long", 32'(btn_long), 32'(m_long));
        check("user_programn", 32'(user_programn), 32'(m_prog));
        if ((btn_press & btn_release) != 7'h0) check("press_and_release", 32'd1, 32'd0);
        for (int i = 0; i < 7; i++) begin
            press_cnt[i] += int'(btn_press[i]);
            rel_cnt[i]   += int'(btn_release[i]);
            long_cnt[i]  += int'(btn_long[i]);
        end
        if (btn_press[3] && first_press3 < 0) first_press3 = cyc_n;
    endtask

    task automatic run(input int n);
        repeat (n) cyc();
    endtask

    int start_cyc, lat, kind, b;

    initial begin
        reset   = 1'b1;
        btn_raw = POL;
        clear_counts();
        run(3);
        check("reset_stable", 32'(btn_stable), 32'd0);
        check("reset_programn", 32'(user_programn), 32'd1);
        reset = 1'b0;
        run(20);

        // Clean press of button 3, then release.
        clear_counts();
        start_cyc = cyc_n;
        btn_raw[3] = 1'b1;
        run(100);
        lat = first_press3 - start_cyc;
        check("press3_latency_in_window", 32'((lat >= 12) && (lat <= 19)), 32'd1);
        check("press3_count", 32'(press_cnt[3]), 32'd1);
        check("others_quiet", 32'(press_cnt[0] + press_cnt[1] + press_cnt[2] + press_cnt[4]
                                 + press_cnt[5] + press_cnt[6]), 32'd0);
        btn_raw[3] = 1'b0;
        run(30);

        // Button 2 chattering every 3 cycles never settles.
        clear_counts();
        for (int k = 0; k < 20; k++) begin
            btn_raw[2] = ~btn_raw[2];
            run(3);
        end
        btn_raw[2] = 1'b0;
        run(20);
        check("chatter2_events", 32'(press_cnt[2] + rel_cnt[2]), 32'd0);

        // Active-low button 0 long hold, then release.
        clear_counts();
        btn_raw[0] = 1'b0;
        run(110);
        check("long0_count", 32'(long_cnt[0]), 32'd1);
        check("hold0_stable", 32'(btn_stable[0]), 32'd1);
        btn_raw[0] = 1'b1;
        run(30);
        check("release0_count", 32'(rel_cnt[0]), 32'd1);

        // Combo of buttons 0 and 1, then release button 1.
        btn_raw[0] = 1'b0;
        btn_raw[1] = 1'b1;
        run(80);
        check("combo_programn_low", 32'(user_programn), 32'd0);
        btn_raw[1] = 1'b0;
        run(25);
        check("combo_programn_high", 32'(user_programn), 32'd1);
        btn_raw[0] = 1'b1;
        run(30);

        // Reset mid-debounce on button 4 while held.
        btn_raw[4] = 1'b1;
        run(10);
        reset = 1'b1;
        run(2);
        check("rst_mid_stable", 32'(btn_stable), 32'd0);
        reset = 1'b0;
        clear_counts();
        run(30);
        check("press4_after_reset", 32'(press_cnt[4]), 32'd1);
        btn_raw[4] = 1'b0;
        run(30);

        // Random mix of glitches, holds, combos and resets.
        for (int s = 0; s < 70; s++) begin
            kind = int'($urandom_range(0, 9));
            b    = int'($urandom_range(0, 6));
            if (kind == 0) begin
                reset = 1'b1;
                run(int'($urandom_range(1, 3)));
                reset = 1'b0;
            end else if (kind <= 3) begin
                btn_raw[b] = ~btn_raw[b];
                run(int'($urandom_range(1, 3)));
                btn_raw[b] = ~btn_raw[b];
                run(int'($urandom_range(1, 6)));
            end else if (kind == 4) begin
                btn_raw[0] = 1'b0;
                btn_raw[1] = 1'b1;
                run(int'($urandom_range(40, 90)));
            end else begin
                btn_raw[b] = ~btn_raw[b];
                run(int'($urandom_range(8, 100)));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/btn_debounce_events.md
BTN_DEBOUNCE_EVENTS -- requirements
Module: btn_debounce_events

Interface
REQ-001 Parameter C_tick_div, default 25000: clk_25mhz cycles per timebase tick (1 ms).
REQ-002 Parameter C_debounce_ticks, default 10: consecutive ticks of a changed input needed to accept the change.
REQ-003 Parameter C_long_ticks, default 1000: ticks of continuous hold before the long-press event.
REQ-004 Parameter C_combo_ticks, default 2000: ticks btn 0 and btn 1 must both be held to assert user_programn low.
REQ-005 Parameter C_active_low, default 7'b0000001: per-bit raw polarity, 1 = pressed reads as 0.
REQ-006 clk_25mhz  in  1  sole clock; reset is synchronous, active-high, sampled on rising clk_25mhz.
REQ-007 reset  in  1  synchronous active-high reset.
REQ-008 btn_raw  in  7  asynchronous button pad inputs.
REQ-009 btn_stable  out  7  debounced state, normalized, 1 = pressed.
REQ-010 btn_press  out  7  one-cycle pulse per bit on accepted press.
REQ-011 btn_release  out  7  one-cycle pulse per bit on accepted release.
REQ-012 btn_long  out  7  one-cycle pulse per bit when hold reaches C_long_ticks.
REQ-013 user_programn  out  1  active-low multiboot request.

Function
REQ-014 Each btn_raw bit SHALL pass through a 2-flop synchronizer, then be XORed with C_active_low to give a normalized sample.
REQ-015 A free-running tick counter SHALL count 0..C_tick_div-1 and wrap, asserting tick for one cycle at wrap.
REQ-016 Per bit, a debounce counter SHALL clear in any cycle where sample equals btn_stable, and increment on tick while they differ.
REQ-017 When the debounce counter would reach C_debounce_ticks, btn_stable SHALL toggle on that clock and the counter SHALL clear.
REQ-018 A glitch shorter than one tick SHALL never change btn_stable, even if it spans a tick edge.
REQ-019 btn_press (btn_release) SHALL be high exactly in the first cycle btn_stable shows 1 (0); never both in one cycle.
REQ-020 Per bit, a hold counter SHALL clear while btn_stable is 0 and increment on tick while 1, saturating at C_long_ticks.
REQ-021 btn_long SHALL pulse once, on the cycle the hold counter reaches C_long_ticks; no repeat until release then re-press.
REQ-022 A combo counter SHALL increment on tick while btn_stable[0] and btn_stable[1] are both 1, saturating at C_combo_ticks; clear otherwise.
REQ-023 user_programn SHALL be 0 while the combo counter equals C_combo_ticks, else 1; it SHALL return to 1 the cycle after either button's release is accepted.
REQ-024 Debounce latency SHALL be between C_debounce_ticks and C_debounce_ticks+1 ticks plus 3 cycles from a clean raw edge.
REQ-025 All outputs SHALL be registered; no combinational path from btn_raw to any output.

Reset
REQ-026 Reset SHALL clear synchronizers to the normalized-0 value, all counters to 0, btn_stable/btn_press/btn_release/btn_long to 0, and user_programn to 1.
REQ-027 Reset asserted mid-debounce or mid-hold SHALL discard the partial count; a button held through reset SHALL be re-debounced afterwards and produce a fresh btn_press.
REQ-028 While reset is high, no event pulse SHALL be asserted.

Structure
REQ-029 Default parameter values and the 7-bit button width SHALL live in a shared constants include used by the top-level passthru designs.
REQ-030 One sub-module btn_debounce_bit (synchronizer, debounce, hold counter, event pulses for one bit) SHALL be instantiated 7 times; tick generator and combo logic stay in the top.

Verification (C_tick_div=4, C_debounce_ticks=3, C_long_ticks=20, C_combo_ticks=10)
REQ-031 Clean press of btn_raw[3] 0->1 held 100 cycles -> btn_stable[3] rises 12-19 cycles later, btn_press[3] one-cycle pulse, no other bits move.
REQ-032 btn_raw[2] toggling every 3 cycles for 60 cycles -> btn_stable[2] stays 0, no press/release pulses.
REQ-033 btn_raw[0] driven 0 (pressed, active-low) held 100 cycles -> btn_stable[0]=1, btn_long[0] single pulse ~80 cycles after btn_stable; release -> btn_release[0] pulse.
REQ-034 btn_raw[0]=0 and btn_raw[1]=1 held -> user_programn low ~40 cycles after both stable; release btn 1 -> user_programn high after debounce.
REQ-035 Reset pulsed 2 cycles while btn_raw[4] held and debounce count at 2 -> all outputs at reset values, then btn_press[4] pulses again after a full debounce interval.
